// File: rtl/seq_recognizer_param_if.sv
// seq_recognizer_param_if: control, pattern-load and status bundle for the serial sequence recogniser
interface seq_recognizer_param_if #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
);
  logic enable;
  logic data_in;
  logic load;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] len_in;
  logic overlap_in;
  logic count_clr;
  logic match_bit;
  logic match_all;
  logic [LEN_W-1:0] progress;
  logic [CNT_W-1:0] match_count;
  logic count_sat;
  modport master (
    output enable, data_in, load, pat_in, len_in, overlap_in, count_clr,
    input match_bit, match_all, progress, match_count, count_sat
  );
  modport slave (
    input enable, data_in, load, pat_in, len_in, overlap_in, count_clr,
    output match_bit, match_all, progress, match_count, count_sat
  );
endinterface

// File: rtl/seq_recognizer_param.sv
// seq_recognizer_param: programmable serial pattern recogniser with prefix progress, overlap control,
// and an optional saturating match counter enabled by defining SEQREC_COUNT_EN.
module seq_recognizer_param #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input logic clk,
  input logic rst,
  seq_recognizer_param_if.slave bus
);
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] valid;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] l;
  logic [LEN_W-1:0] progress;
  logic ovl;
  logic match_all;
  function automatic logic [PAT_W-1:0] msk(input logic [LEN_W-1:0] n);
    logic [PAT_W:0] t;
    t = (PAT_W + 1)'(1) << n;
    return t[PAT_W-1:0] - PAT_W'(1);
  endfunction
  assign l = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign match_all = (len != '0) && (valid >= l) && (((hist ^ pat) & msk(l)) == '0);
  // newest k history bits against the first k pattern bits, Pat[l-1 -: k]; largest hit wins
  always_comb begin
    progress = '0;
    for (int k = 1; k < PAT_W; k++)
      if (LEN_W'(k) < l && LEN_W'(k) <= valid &&
          (((hist ^ (pat >> (l - LEN_W'(k)))) & msk(LEN_W'(k))) == '0))
        progress = LEN_W'(k);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      valid <= '0;
      pat <= PAT_W'(16'h00FD);
      len <= LEN_W'(8);
      ovl <= 1'b1;
    end else if (bus.load) begin
      hist <= '0;
      valid <= '0;
      pat <= bus.pat_in;
      len <= bus.len_in;
      ovl <= bus.overlap_in;
    end else if (bus.enable) begin
      hist <= {hist[PAT_W-2:0], bus.data_in};
      valid <= (!ovl && match_all) ? LEN_W'(1) : (valid == LEN_W'(PAT_W)) ? valid : valid + 1'b1;
    end
  assign bus.match_all = match_all;
  assign bus.progress = progress;
  assign bus.match_bit = match_all | (progress != '0);
`ifdef SEQREC_COUNT_EN
  logic [CNT_W-1:0] cnt;
  // a match is consumed only by a real sample; a load discards that edge's bit
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (bus.count_clr) cnt <= '0;
    else if (bus.enable && !bus.load && match_all && !(&cnt)) cnt <= cnt + 1'b1;
  assign bus.match_count = cnt;
  assign bus.count_sat = &cnt;
`else
  logic unused_clr;
  assign unused_clr = bus.count_clr;
  assign bus.match_count = '0;
  assign bus.count_sat = 1'b0;
`endif
endmodule

// File: tb/tb_seq_recognizer_param.sv
// tb_seq_recognizer_param: randomized and directed checks against a queue-based model of the recogniser
module tb_seq_recognizer_param;
  localparam int PAT_W = 16;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CMAX = (1 << CNT_W) - 1;
`ifdef SEQREC_COUNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  typedef logic [2+LEN_W+CNT_W:0] ov_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bit q[$];
  logic [PAT_W-1:0] mpat;
  int mlen;
  bit movl;
  int mcnt;
  seq_recognizer_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) intf ();
  seq_recognizer_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(intf.slave));
  always #5 clk = ~clk;
  function automatic int eff_len();
    return (mlen > PAT_W) ? PAT_W : mlen;
  endfunction
  // expected bit i of the sequence is mpat[L-1-i]; compare against the newest received bits
  function automatic bit m_match();
    int l = eff_len();
    int n = q.size();
    if (l == 0 || n < l) return 1'b0;
    for (int i = 0; i < l; i++) if (q[n-l+i] != mpat[l-1-i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int m_prog();
    int l = eff_len();
    int n = q.size();
    int best = 0;
    bit ok;
    for (int k = 1; k < l; k++)
      if (k <= n) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) if (q[n-k+i] != mpat[l-1-i]) ok = 1'b0;
        if (ok) best = k;
      end
    return best;
  endfunction
  function automatic ov_t exp_vec();
    bit ma = m_match();
    int pr = m_prog();
    int c = CEN ? mcnt : 0;
    return {(pr != 0) || ma, ma, LEN_W'(pr), CNT_W'(c), CEN && (mcnt == CMAX)};
  endfunction
  function automatic ov_t obs_vec();
    return {intf.match_bit, intf.match_all, intf.progress, intf.match_count, intf.count_sat};
  endfunction
  task automatic model_reset();
    q.delete();
    mpat = 16'h00FD;
    mlen = 8;
    movl = 1'b1;
    mcnt = 0;
  endtask
  task automatic model_edge(input bit en, d, ld, input logic [PAT_W-1:0] p, input int l, input bit o, clr);
    bit ma = m_match();
    if (ld) begin
      q.delete();
      mpat = p;
      mlen = l;
      movl = o;
    end else if (en) begin
      if (!movl && ma) q.delete();
      q.push_back(d);
      if (q.size() > PAT_W) void'(q.pop_front());
    end
    if (clr) mcnt = 0;
    else if (en && !ld && ma && mcnt < CMAX) mcnt++;
  endtask
  task automatic drive(input bit en, d, ld, input logic [PAT_W-1:0] p, input int l, input bit o, clr);
    intf.enable = en;
    intf.data_in = d;
    intf.load = ld;
    intf.pat_in = p;
    intf.len_in = LEN_W'(l);
    intf.overlap_in = o;
    intf.count_clr = clr;
    @(posedge clk);
    model_edge(en, d, ld, p, l, o, clr);
    #1;
  endtask
  task automatic test_reset();
    total++;
    if (obs_vec() !== ov_t'(0)) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs_vec(), ov_t'(0));
    end
    total++;
    if (exp_vec() !== obs_vec()) begin
      bad++;
      $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask
  task automatic test_default_pattern();
    bit seq[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      drive(1, (i < 8) ? seq[i] : 1'b0, 0, '0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL default_bit%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_overlap(input bit o);
    bit seq[6] = '{1, 0, 1, 0, 1, 1};
    drive(1, 0, 1, 16'b101, 3, o, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, seq[i], 0, '0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL overlap%0d_bit%0d got=%h want=%h", o, i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_load_midstream();
    bit seq[3] = '{1, 0, 1};
    bit full[4] = '{1, 0, 1, 1};
    drive(1, 0, 1, 16'b1011, 4, 1, 0);
    foreach (seq[i]) drive(1, seq[i], 0, '0, 0, 0, 0);
    drive(1, 1, 1, 16'b1011, 4, 1, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL load_mid_discard got=%h want=%h", obs_vec(), exp_vec());
    end
    foreach (full[i]) begin
      drive(1, full[i], 0, '0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL load_mid_bit%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_hold();
    drive(1, 0, 1, 16'b11, 2, 1, 0);
    drive(1, 1, 0, '0, 0, 0, 0);
    drive(1, 1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'($urandom), 0, '0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL hold_cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_len_zero();
    drive(1, 0, 1, 16'hFFFF, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, '0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec() || intf.match_bit !== 1'b0) begin
        bad++;
        $display("FAIL len_zero_bit%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_count_sat_clr();
    drive(1, 0, 1, 16'b1, 1, 1, 1);
    for (int i = 0; i < CMAX + 10; i++) drive(1, 1, 0, '0, 0, 0, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL count_sat got=%h want=%h", obs_vec(), exp_vec());
    end
    drive(1, 1, 0, '0, 0, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL count_clr_on_match got=%h want=%h", obs_vec(), exp_vec());
    end
    drive(1, 0, 0, '0, 0, 0, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL count_after_clr got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask
  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 4000; i++) begin
      bit ld = ($urandom_range(0, 39) == 0);
      int l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 5);
      drive($urandom_range(0, 7) != 0, 1'($urandom), ld, PAT_W'($urandom), l, 1'($urandom),
            $urandom_range(0, 49) == 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        errs++;
        if (errs < 20) $display("FAIL random_cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_async_reset();
    bit seq[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    drive(1, 0, 1, 16'b1111, 4, 1, 0);
    drive(1, 1, 0, '0, 0, 0, 0);
    drive(1, 1, 0, '0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== ov_t'(0)) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", obs_vec(), ov_t'(0));
    end
    #1 rst = 1'b0;
    foreach (seq[i]) begin
      drive(1, seq[i], 0, '0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL post_reset_bit%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (intf.match_all !== 1'b1) begin
      bad++;
      $display("FAIL default_restored got=%b want=1", intf.match_all);
    end
  endtask
  initial begin
    intf.enable = 1'b0;
    intf.data_in = 1'b0;
    intf.load = 1'b0;
    intf.pat_in = '0;
    intf.len_in = '0;
    intf.overlap_in = 1'b0;
    intf.count_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_default_pattern();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_load_midstream();
    test_hold();
    test_len_zero();
    test_count_sat_clr();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
